// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer.
// It drives CKE and the command/address bus through the JEDEC init sequence,
// then holds NOP with CKE high and raises done_o until reset.
module ddr2_init_seq #(
  parameter int BA_WIDTH       = 3,
  parameter int ADDR_WIDTH     = 14,
  parameter int T_INIT_CYCLES  = 200,
  parameter int T_CKE_CYCLES   = 80,
  parameter int T_RP_CYCLES    = 4,
  parameter int T_MRD_CYCLES   = 2,
  parameter int T_RFC_CYCLES   = 26,
  parameter int T_DLLK_CYCLES  = 200,
  parameter int CAS_LATENCY    = 5,
  parameter int WRITE_RECOVERY = 6,
  parameter int BURST_TYPE     = 1,
  parameter int BURST_LEN_CODE = 2,
  parameter logic [ADDR_WIDTH-1:0] EMR1_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cke_o,
  output logic                  cs_n_o,
  output logic                  ras_n_o,
  output logic                  cas_n_o,
  output logic                  we_n_o,
  output logic [BA_WIDTH-1:0]   ba_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  odt_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max_of(max_of(max_of(T_INIT_CYCLES, T_CKE_CYCLES),
                                       max_of(T_RP_CYCLES, T_MRD_CYCLES)),
                                max_of(T_RFC_CYCLES, T_DLLK_CYCLES));
  localparam int CW = $clog2(T_MAX) + 1;
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PWR, S_WAIT_CKE, S_SEQ, S_DONE
  } state_t;

  typedef struct packed {
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [BA_WIDTH-1:0]   ba;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         gap;
  } cmd_t;

  // Mode register word; bits above A12 stay zero.
  function automatic logic [ADDR_WIDTH-1:0] mr_word(input logic dll_reset);
    logic [ADDR_WIDTH-1:0] v;
    v       = '0;
    v[11:9] = 3'(WRITE_RECOVERY - 1);
    v[8]    = dll_reset;
    v[6:4]  = 3'(CAS_LATENCY);
    v[3]    = 1'(BURST_TYPE);
    v[2:0]  = 3'(BURST_LEN_CODE);
    return v;
  endfunction

  // EMR1 word with the OCD field A[9:7] overridden by the sequence.
  function automatic logic [ADDR_WIDTH-1:0] emr1_word(input logic [2:0] ocd);
    logic [ADDR_WIDTH-1:0] v;
    v      = EMR1_BASE;
    v[9:7] = ocd;
    return v;
  endfunction

  // Command table: bus encoding and gap to the following command (or done).
  function automatic cmd_t cmd_entry(input logic [3:0] i);
    cmd_t c;
    c = '{ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0, ba: '0, addr: '0, gap: CW'(T_MRD_CYCLES)};
    case (i)
      4'd0, 4'd5: begin
        c.cas_n   = 1'b1;
        c.addr[10] = 1'b1;
        c.gap     = CW'(T_RP_CYCLES);
      end
      4'd1:  c.ba = BA_WIDTH'(2);
      4'd2:  c.ba = BA_WIDTH'(3);
      4'd3:  begin c.ba = BA_WIDTH'(1); c.addr = emr1_word(3'b000); end
      4'd4:  c.addr = mr_word(1'b1);
      4'd6, 4'd7: begin
        c.we_n = 1'b1;
        c.gap  = CW'(T_RFC_CYCLES);
      end
      4'd8:  c.addr = mr_word(1'b0);
      4'd9:  begin c.ba = BA_WIDTH'(1); c.addr = emr1_word(3'b111); end
      4'd10: begin
        c.ba   = BA_WIDTH'(1);
        c.addr = emr1_word(3'b000);
        c.gap  = CW'(T_DLLK_CYCLES);
      end
      default: c = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, addr: '0, gap: CW'(1)};
    endcase
    return c;
  endfunction

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [3:0]            idx, idx_nx;
  logic                  busy_nx, done_nx, cke_nx, cs_n_nx, ras_n_nx, cas_n_nx, we_n_nx;
  logic [BA_WIDTH-1:0]   ba_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  issue;
  cmd_t                  cur;

  assign cur   = cmd_entry(idx);
  assign odt_o = 1'b0;

  // Next-state, wait counter and next bus values; the bus defaults to NOP.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    busy_nx  = busy_o;
    done_nx  = done_o;
    cke_nx   = cke_o;
    cs_n_nx  = 1'b0;
    ras_n_nx = 1'b1;
    cas_n_nx = 1'b1;
    we_n_nx  = 1'b1;
    ba_nx    = '0;
    addr_nx  = '0;
    issue    = 1'b0;
    case (state)
      S_IDLE: begin
        cs_n_nx = 1'b1;
        if (start_i) begin
          state_nx = S_WAIT_PWR;
          busy_nx  = 1'b1;
          idx_nx   = '0;
          cnt_nx   = CW'(T_INIT_CYCLES - 1);
        end
      end
      S_WAIT_PWR: begin
        if (cnt == '0) begin
          state_nx = S_WAIT_CKE;
          cke_nx   = 1'b1;
          cnt_nx   = CW'(T_CKE_CYCLES - 1);
        end else begin
          cs_n_nx = 1'b1;
          cnt_nx  = cnt - CW'(1);
        end
      end
      S_WAIT_CKE: begin
        if (cnt == '0) begin
          issue    = 1'b1;
          state_nx = S_SEQ;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_SEQ: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (idx == LAST_IDX) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      S_DONE:  ;
      default: state_nx = S_IDLE;
    endcase
    if (issue) begin
      ras_n_nx = cur.ras_n;
      cas_n_nx = cur.cas_n;
      we_n_nx  = cur.we_n;
      ba_nx    = cur.ba;
      addr_nx  = cur.addr;
      cnt_nx   = cur.gap - CW'(1);
      idx_nx   = idx + 4'd1;
    end
  end

  // State, counter and registered DRAM outputs; reset aborts to power-up values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      cke_o   <= 1'b0;
      cs_n_o  <= 1'b1;
      ras_n_o <= 1'b1;
      cas_n_o <= 1'b1;
      we_n_o  <= 1'b1;
      ba_o    <= '0;
      addr_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      busy_o  <= busy_nx;
      done_o  <= done_nx;
      cke_o   <= cke_nx;
      cs_n_o  <= cs_n_nx;
      ras_n_o <= ras_n_nx;
      cas_n_o <= cas_n_nx;
      we_n_o  <= we_n_nx;
      ba_o    <= ba_nx;
      addr_o  <= addr_nx;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Self-checking bench for ddr2_init_seq: randomized start timing, start holds,
// stray start pulses and mid-sequence resets, compared cycle by cycle against
// a timeline model built from the command list and gap rules.
module tb_ddr2_init_seq;

  localparam int INIT = 10, CKE = 4, RP = 3, MRD = 2, RFC = 8, DLLK = 20;
  localparam int CL = 5, WR = 6, BT = 1, BLC = 2;
  localparam int NCMD = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        busy_o, done_o, cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, odt_o;
  logic [2:0]  ba_o;
  logic [13:0] addr_o;

  int total = 0;
  int bad   = 0;

  // Expected timeline: edge offset (from start acceptance) and bus fields per command.
  int          ct   [NCMD];
  logic [2:0]  crcw [NCMD];
  logic [2:0]  cba  [NCMD];
  logic [13:0] caddr[NCMD];
  int          done_time;

  ddr2_init_seq #(
    .BA_WIDTH(3), .ADDR_WIDTH(14),
    .T_INIT_CYCLES(INIT), .T_CKE_CYCLES(CKE), .T_RP_CYCLES(RP),
    .T_MRD_CYCLES(MRD), .T_RFC_CYCLES(RFC), .T_DLLK_CYCLES(DLLK),
    .CAS_LATENCY(CL), .WRITE_RECOVERY(WR), .BURST_TYPE(BT), .BURST_LEN_CODE(BLC),
    .EMR1_BASE(14'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .cke_o(cke_o), .cs_n_o(cs_n_o),
    .ras_n_o(ras_n_o), .cas_n_o(cas_n_o), .we_n_o(we_n_o),
    .ba_o(ba_o), .addr_o(addr_o), .odt_o(odt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mr_val(input int dll);
    return ((WR - 1) << 9) + (dll << 8) + (CL << 4) + (BT << 3) + BLC;
  endfunction

  function automatic int emr1_val(input int ocd);
    return ocd << 7;
  endfunction

  // Fill the command timeline from the init command list and its gaps.
  task automatic build_model();
    int gaps[NCMD];
    int t;
    gaps = '{RP, MRD, MRD, MRD, MRD, RP, RFC, RFC, MRD, MRD, DLLK};
    crcw = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    cba  = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    caddr[0]  = 14'(1 << 10);
    caddr[1]  = 14'd0;
    caddr[2]  = 14'd0;
    caddr[3]  = 14'(emr1_val(0));
    caddr[4]  = 14'(mr_val(1));
    caddr[5]  = 14'(1 << 10);
    caddr[6]  = 14'd0;
    caddr[7]  = 14'd0;
    caddr[8]  = 14'(mr_val(0));
    caddr[9]  = 14'(emr1_val(7));
    caddr[10] = 14'(emr1_val(0));
    t = INIT + CKE;
    for (int i = 0; i < NCMD; i++) begin
      ct[i] = t;
      t += gaps[i];
    end
    done_time = t;
  endtask

  function automatic logic [31:0] pack(input logic cke, input logic cs, input logic [2:0] rcw,
                                       input logic [2:0] ba, input logic [13:0] addr,
                                       input logic busy, input logic done, input logic odt);
    return {7'd0, cke, cs, rcw, ba, addr, busy, done, odt};
  endfunction

  function automatic logic [31:0] sample();
    return pack(cke_o, cs_n_o, {ras_n_o, cas_n_o, we_n_o}, ba_o, addr_o, busy_o, done_o, odt_o);
  endfunction

  // Expected outputs k edges after acceptance; k < 0 means idle / reset.
  function automatic logic [31:0] exp_vec(input int k);
    if (k < 0) return pack(1'b0, 1'b1, 3'b111, 3'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    if (k < INIT) return pack(1'b0, 1'b1, 3'b111, 3'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NCMD; i++)
      if (ct[i] == k) return pack(1'b1, 1'b0, crcw[i], cba[i], caddr[i], 1'b1, 1'b0, 1'b0);
    return pack(1'b1, 1'b0, 3'b111, 3'd0, 14'd0, k < done_time, k >= done_time, 1'b0);
  endfunction

  task automatic do_reset(input int run);
    start_i = 1'b0;
    rst_n   = 1'b0;
    #1 check($sformatf("r%0d_reset", run), sample(), exp_vec(-1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One init run: idle cycles, start held `hold` edges, optional reset at offset abort_k.
  task automatic run(input int id, input int pre, input int hold, input int abort_k);
    int ncmd = 0;
    do_reset(id);
    for (int i = 0; i < pre; i++) begin
      @(negedge clk);
      check($sformatf("r%0d_idle%0d", id, i), sample(), exp_vec(-1));
    end
    start_i = 1'b1;
    for (int k = 0; k < done_time + 12; k++) begin
      @(negedge clk);
      check($sformatf("r%0d_k%0d", id, k), sample(), exp_vec(k));
      if (!cs_n_o && {ras_n_o, cas_n_o, we_n_o} != 3'b111) ncmd++;
      start_i = (k < hold - 1) ? 1'b1 : ($urandom_range(0, 5) == 0);
      if (k == abort_k) begin
        start_i = 1'b0;
        rst_n   = 1'b0;
        #1 check($sformatf("r%0d_abort", id), sample(), exp_vec(-1));
        @(posedge clk);
        #1 check($sformatf("r%0d_abort_hold", id), sample(), exp_vec(-1));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check($sformatf("r%0d_cmd_count", id), 32'(ncmd), 32'(NCMD));
    start_i = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    build_model();
    @(negedge clk);
    run(0, $urandom_range(1, 6), 1, -1);
    run(1, $urandom_range(1, 6), 5, -1);
    run(2, $urandom_range(1, 6), 1, $urandom_range(ct[6], ct[7] - 1));
    run(3, $urandom_range(1, 6), 1, -1);
    run(4, $urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, done_time - 1));
    run(5, $urandom_range(1, 6), $urandom_range(1, 5), -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
